// File: rtl/serial_rx.sv
// UART-style serial receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
// Optional even-parity bit is compiled in when SERIAL_RX_PARITY_EN is defined.
module serial_rx #(
  parameter int CYCLES_PER_BIT = 868
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       data_in,
  input  logic       big_endian,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       busy_out,
  output logic       framing_err_out,
  output logic       parity_err_out
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  function automatic logic [7:0] reverse8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = d[i];
    end
    return r;
  endfunction

`ifdef SERIAL_RX_PARITY_EN
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ~((^d) ^ p);
  endfunction
`endif

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic [7:0]       byte_d;
  logic             valid_q;
  logic             busy_q;
  logic             ferr_q;
  logic             fall_s;
  logic             half_tick_s;
  logic             bit_tick_s;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_q;
  logic             perr_q;
`endif

  assign fall_s      = prev_q & ~sync2_q;
  assign half_tick_s = (cnt_q == CNT_HALF);
  assign bit_tick_s  = (cnt_q == CNT_LAST);
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign byte_d      = big_endian ? reverse8(shift_q) : shift_q;

  // Line synchronizer and edge-detect history; idle-high line means reset to 1.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame FSM with bit timing and registered result outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          cnt_q     <= CNT_ZERO;
          bit_idx_q <= 3'd0;
          if (fall_s) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_START: begin
          if (half_tick_s) begin
            cnt_q <= CNT_ZERO;
            // A high line at mid-start means the edge was a glitch.
            if (sync2_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          if (bit_tick_s) begin
            cnt_q              <= CNT_ZERO;
            shift_q[bit_idx_q] <= sync2_q;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick_s) begin
            cnt_q   <= CNT_ZERO;
            par_q   <= sync2_q;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif
        S_STOP: begin
          if (bit_tick_s) begin
            cnt_q   <= CNT_ZERO;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (!sync2_q) begin
              ferr_q <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            end else if (!parity_ok(shift_q, par_q)) begin
              perr_q <= 1'b1;
`endif
            end else begin
              data_q  <= byte_d;
              valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= CNT_ZERO;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out        = data_q;
  assign valid_out       = valid_q;
  assign busy_out        = busy_q;
  assign framing_err_out = ferr_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err_out  = perr_q;
`else
  assign parity_err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed table, corner sequences and randomized frames
// compared against a frame-level reference model (honours SERIAL_RX_PARITY_EN).
module tb_serial_rx;

  localparam int P = 8;
  localparam int H = P / 2;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NB     = 10;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NB     = 9;
`endif
  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       big_endian;
  logic [7:0] data_out;
  logic       valid_out;
  logic       busy_out;
  logic       framing_err_out;
  logic       parity_err_out;

  serial_rx #(.CYCLES_PER_BIT(P)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .data_in         (data_in),
    .big_endian      (big_endian),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .busy_out        (busy_out),
    .framing_err_out (framing_err_out),
    .parity_err_out  (parity_err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       be0;
    logic       be1;
    logic       stop;
    logic       pflip;
    int         gap;
    logic [2:0] kind;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[$];

  logic [7:0] ref_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every result pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1 || framing_err_out === 1'b1 || parity_err_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({valid_out, framing_err_out, parity_err_out}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'({valid_out, framing_err_out, parity_err_out}), 32'(e.kind));
        check("data_out", 32'(data_out), 32'(e.data));
        check("pulse_cycle", 32'(cyc), 32'(e.at));
        check("busy_at_result", 32'(busy_out), 32'd0);
      end
    end
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    int r = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r + (1 << (7 - i));
    end
    return 8'(r);
  endfunction

  task automatic idle(input int n);
    data_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; called and returns at posedge+1.
  task automatic send_frame(input logic [7:0] b, input logic be0, input logic be1,
                            input logic stop, input logic pflip, input int gap,
                            input logic [2:0] kind, input logic [7:0] exp_data);
    exp_t e;
    big_endian = be0;
    data_in    = 1'b0;
    e.kind = kind;
    e.data = exp_data;
    e.at   = cyc + 3 + H + NB * P;
    exp_q.push_back(e);
    repeat (P) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      repeat (P) @(posedge clk);
      #1;
    end
    if (PAR_EN) begin
      data_in = (^b) ^ pflip;
      repeat (P) @(posedge clk);
      #1;
    end
    big_endian = be1;
    data_in    = stop;
    repeat (P) @(posedge clk);
    #1;
    if (gap > 0) begin
      data_in = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic model_send(input logic [7:0] b, input logic be0, input logic be1,
                            input logic stop, input logic pflip, input int gap);
    logic [2:0] k;
    logic [7:0] d;
    if (!stop) begin
      k = K_FERR;
      d = ref_data;
    end else if (PAR_EN && pflip) begin
      k = K_PERR;
      d = ref_data;
    end else begin
      k = K_VALID;
      d = be1 ? rev8(b) : b;
      ref_data = d;
    end
    send_frame(b, be0, be1, stop, pflip, gap, k, d);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40 * P) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"}, 32'(data_out), 32'd0);
    check({name, "_valid"}, 32'(valid_out), 32'd0);
    check({name, "_busy"}, 32'(busy_out), 32'd0);
    check({name, "_ferr"}, 32'(framing_err_out), 32'd0);
    check({name, "_perr"}, 32'(parity_err_out), 32'd0);
  endtask

  initial begin
    int         c0;
    logic [7:0] rb;
    logic       rbe0;
    logic       rbe1;
    logic       rstop;
    logic       rpf;
    int         rgap;

    rst        = 1'b1;
    data_in    = 1'b1;
    big_endian = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2 * P);

    tbl.push_back('{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 0, K_VALID, 8'hA5});
    tbl.push_back('{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 0, K_VALID, 8'h80});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2, K_FERR,  8'h80});
    tbl.push_back('{8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 0, K_VALID, 8'hF0});
    tbl.push_back('{8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 0, K_VALID, 8'h0F});
    tbl.push_back('{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 0, K_VALID, 8'hC3});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3, K_VALID, 8'h00});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 0, K_VALID, 8'hFF});
    if (PAR_EN) begin
      tbl.push_back('{8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 0, K_VALID, 8'h07});
      tbl.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 0, K_PERR,  8'h07});
      tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 2, K_FERR,  8'h07});
    end
    foreach (tbl[i]) begin
      send_frame(tbl[i].data, tbl[i].be0, tbl[i].be1, tbl[i].stop, tbl[i].pflip,
                 tbl[i].gap, tbl[i].kind, tbl[i].exp_data);
      ref_data = tbl[i].exp_data;
    end
    drain("table_drain");
    idle(P);

    // Two-cycle low glitch: busy for H cycles after the edge, then silent.
    data_in = 1'b0;
    c0 = cyc;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    data_in = 1'b1;
    while (cyc < c0 + H + 4) begin
      @(negedge clk);
      check("glitch_busy", 32'(busy_out), 32'(cyc >= c0 + 3 && cyc <= c0 + 2 + H));
    end
    @(posedge clk);
    #1;
    idle(P);
    model_send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    drain("after_glitch_drain");

    // Bad stop bit, then the line stays low: no re-trigger without a fresh edge.
    model_send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (P) @(posedge clk);
      #1;
      check("held_low_busy", 32'(busy_out), 32'd0);
    end
    drain("held_low_drain");
    idle(P);

    // Asynchronous reset in the middle of data bit 4 of 0xFF.
    data_in = 1'b0;
    repeat (P) @(posedge clk);
    #1;
    data_in = 1'b1;
    repeat (4 * P + H) @(posedge clk);
    #1;
    check("busy_before_reset", 32'(busy_out), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_data = 8'h00;
    idle(2 * P);
    model_send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    drain("after_reset_drain");

    // Back-to-back frames with no idle gap.
    model_send(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    model_send(8'h34, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    model_send(8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    drain("b2b_drain");

    for (int i = 0; i < 24; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rbe0  = 1'($urandom_range(0, 1));
      rbe1  = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 5) != 0);
      rpf   = PAR_EN && ($urandom_range(0, 4) == 0);
      rgap  = rstop ? $urandom_range(0, 3) : $urandom_range(1, 3);
      model_send(rb, rbe0, rbe1, rstop, rpf, rgap);
    end
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
# serial_rx

Serial receiver at the far end of the board's serial link. It deserializes one UART-style frame from a single input pin and delivers the byte on a parallel output. `big_endian` lets the received byte be bit-reversed, undoing the transmit-side endian swap. The block sits between a Pmod input pin (e.g. `ja[1]`) and display/counter logic on the same 100 MHz clock domain as the transmitter.

## Interface
Parameters:
- `CYCLES_PER_BIT`, default 868: clocks per bit period (100 MHz / 115200). Must be ≥ 4.

Ports (one clock; reset is asynchronous and active-high):
- `clk_in`  input  1  system clock (`clk_100mhz` at top level)
- `rst_in`  input  1  asynchronous, active-high reset (`btnd` at top level)
- `data_in`  input  1  serial line, asynchronous to `clk_in`; idles high
- `big_endian`  input  1  when 1, the output byte is bit-reversed
- `data_out`  output  8  last good byte; held between frames
- `valid_out`  output  1  one-cycle pulse when `data_out` updates
- `busy_out`  output  1  high in every state except IDLE
- `framing_err_out`  output  1  one-cycle pulse on a bad stop bit
- `parity_err_out`  output  1  one-cycle pulse on a parity mismatch (macro-dependent)

## Operation
- Frame format: start bit (0), 8 data bits with `send_data[0]` first, optional even-parity bit, stop bit (1). Each bit lasts `CYCLES_PER_BIT` clocks.
- Input path: a 2-flop synchronizer feeds the line into the FSM, followed by a previous-sample flop used for edge detection. All three flops reset to 1.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: leaves on a synchronized falling edge (previous sample 1, current 0). A line held low never re-triggers.
- START: waits `CYCLES_PER_BIT/2` (floor) clocks, then samples the line.
  - Sample is 0: load the counter and go to DATA.
  - Sample is 1: glitch. Return to IDLE with no output pulse.
- DATA: samples once per `CYCLES_PER_BIT`. Received bit k is stored at shift position k (k = 0..7). After bit 7, go to PARITY or STOP.
- PARITY: samples one bit and checks that XOR of the 8 data bits and the parity bit equals 0.
- STOP: samples one bit, then returns to IDLE.
  - Stop = 1 and parity OK: `data_out` takes `big_endian ? reverse(shift) : shift`, and `valid_out` pulses.
  - Stop = 0: `framing_err_out` pulses, `data_out` is unchanged, `valid_out` stays 0. The framing error takes priority over a parity error.
  - Stop = 1 but parity bad: `parity_err_out` pulses, `data_out` is unchanged.
- `big_endian` is sampled only in the STOP-state update cycle. Changes mid-frame have no effect.
- The bit counter runs 0..`CYCLES_PER_BIT`-1 and is sized with `$clog2(CYCLES_PER_BIT)`. The bit index is 3 bits.

## Timing
- Let E be the cycle in which the synchronized falling edge is detected. H = `CYCLES_PER_BIT/2`, P = `CYCLES_PER_BIT`.
- Start sample: E+H. Data bit k sample: E+H+(k+1)·P. Parity sample: E+H+9P. Stop sample: E+H+9P without the macro, E+H+10P with it.
- `data_out`, `valid_out` and the error pulses are registered. They are visible in the cycle after the stop sample, and each pulse is exactly 1 cycle.
- Pin-to-edge latency is 3 cycles (two synchronizer flops plus the edge flop).
- `busy_out` rises the cycle after E. It falls in the same cycle the result pulses.
- A start edge in the cycle immediately after the return to IDLE is accepted. Back-to-back frames are supported.
- Reset, asynchronous and allowed mid-frame: state IDLE; `data_out`=0x00; `valid_out`, `busy_out` and all error outputs = 0; counters = 0. A partial frame is discarded.

## Configuration
- `SERIAL_RX_PARITY_EN` defined: the PARITY state exists, frames are 11 bits, and `parity_err_out` is live.
- Not defined: frames are 10 bits, PARITY is not compiled, and `parity_err_out` is tied to 0.

## Test plan
- CYCLES_PER_BIT=8, big_endian=0, frame 0xA5 -> `data_out`=0xA5 with `valid_out` high 1 cycle at E+4+72+1; `busy_out` then low.
- big_endian=1, frame 0x01 -> `data_out`=0x80. Toggling big_endian mid-frame on frame 0x0F -> the result follows the value at the stop cycle.
- Frame 0x3C with stop bit 0 -> `framing_err_out` 1-cycle pulse, no `valid_out`, `data_out` keeps 0x80. Line held low afterwards -> no new frame until a fresh falling edge.
- 2-cycle low glitch (less than H=4) -> `busy_out` pulses, then IDLE; no `valid_out` or errors. A following frame 0x55 is received correctly.
- Assert `rst_in` during data bit 4 of frame 0xFF -> all outputs 0 immediately. The next frame 0x3C -> `data_out`=0x3C.
- With `SERIAL_RX_PARITY_EN`: 0x07 with parity bit 1 -> valid. 0x07 with parity bit 0 -> `parity_err_out` pulse, no `valid_out`.
